regfile_client: RTL and testbench

Initiator side of the CPU register-file strobe/acknowledge protocol. Accepts register read requests from the decode stage and register write requests from the writeback stage using valid/ready handshakes. Converts each request into a single-cycle strobe toward the register file, waits for the matching acknowledge, and returns read data or write completion to the requester. Sits between the pipeline stages and the regfile. It serialises traffic so that only one register-file transaction is outstanding at any time.

---
 rtl/regfile_client.sv | 170 +++++++++++++++++
 tb/tb_regfile_client.sv | 548 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_client.sv
// Initiator for the register-file strobe/acknowledge protocol; serialises decode reads and writeback writes.
// Optional abandon-on-silence watchdog is compiled in with `define REGFILE_TIMEOUT_EN.
module regfile_client #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rd_req_i,
    input  logic [4:0]  rd_rs1_i,
    input  logic [4:0]  rd_rs2_i,
    output logic        rd_ready_o,
    output logic        rd_valid_o,
    output logic [31:0] rd_rs1_data_o,
    output logic [31:0] rd_rs2_data_o,
    input  logic        wr_req_i,
    input  logic [4:0]  wr_rd_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    output logic        wr_done_o,
    output logic        stb_read_o,
    output logic [4:0]  op_rs1_o,
    output logic [4:0]  op_rs2_o,
    input  logic        ack_read_i,
    input  logic [31:0] reg_rs1_i,
    input  logic [31:0] reg_rs2_i,
    output logic        stb_write_o,
    output logic [4:0]  op_rd_o,
    output logic [31:0] reg_rd_o,
    input  logic        ack_write_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WR = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        stb_read_d, stb_write_d, rd_valid_d, wr_done_d;
    logic [4:0]  op_rs1_d, op_rs2_d, op_rd_d;
    logic [31:0] reg_rd_d, rd_rs1_data_d, rd_rs2_data_d;
    logic        ack_rd_ok, ack_wr_ok;

    // An acknowledge seen while our own strobe is still high is too early to count.
    assign ack_rd_ok = ack_read_i & ~stb_read_o;
    assign ack_wr_ok = ack_write_i & ~stb_write_o;

    assign wr_ready_o = (state_q == IDLE);
    assign rd_ready_o = (state_q == IDLE) & ~wr_req_i;

`ifdef REGFILE_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       expired;
    logic       timeout_d;

    assign expired    = (wait_cnt_q == CNT_LAST);
    assign wait_cnt_d = (state_q == IDLE) ? '0 : wait_cnt_q + 8'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_q <= '0;
            timeout_o  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_o  <= timeout_d;
        end
    end
`else
    logic [7:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
    assign timeout_o          = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        stb_read_d    = 1'b0;
        stb_write_d   = 1'b0;
        rd_valid_d    = 1'b0;
        wr_done_d     = 1'b0;
        op_rs1_d      = op_rs1_o;
        op_rs2_d      = op_rs2_o;
        op_rd_d       = op_rd_o;
        reg_rd_d      = reg_rd_o;
        rd_rs1_data_d = rd_rs1_data_o;
        rd_rs2_data_d = rd_rs2_data_o;
`ifdef REGFILE_TIMEOUT_EN
        timeout_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wr_req_i) begin
                    op_rd_d  = wr_rd_i;
                    reg_rd_d = wr_data_i;
                    // x0 is hardwired to zero, so the regfile is never bothered.
                    if (wr_rd_i != 5'd0) begin
                        stb_write_d = 1'b1;
                        state_d     = WAIT_WR;
                    end else begin
                        wr_done_d = 1'b1;
                    end
                end else if (rd_req_i) begin
                    op_rs1_d   = rd_rs1_i;
                    op_rs2_d   = rd_rs2_i;
                    stb_read_d = 1'b1;
                    state_d    = WAIT_RD;
                end
            end
            WAIT_WR: begin
                if (ack_wr_ok) begin
                    wr_done_d = 1'b1;
                    state_d   = IDLE;
                end
`ifdef REGFILE_TIMEOUT_EN
                else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            WAIT_RD: begin
                if (ack_rd_ok) begin
                    rd_rs1_data_d = reg_rs1_i;
                    rd_rs2_data_d = reg_rs2_i;
                    rd_valid_d    = 1'b1;
                    state_d       = IDLE;
                end
`ifdef REGFILE_TIMEOUT_EN
                else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            stb_read_o    <= 1'b0;
            stb_write_o   <= 1'b0;
            rd_valid_o    <= 1'b0;
            wr_done_o     <= 1'b0;
            op_rs1_o      <= '0;
            op_rs2_o      <= '0;
            op_rd_o       <= '0;
            reg_rd_o      <= '0;
            rd_rs1_data_o <= '0;
            rd_rs2_data_o <= '0;
        end else begin
            state_q       <= state_d;
            stb_read_o    <= stb_read_d;
            stb_write_o   <= stb_write_d;
            rd_valid_o    <= rd_valid_d;
            wr_done_o     <= wr_done_d;
            op_rs1_o      <= op_rs1_d;
            op_rs2_o      <= op_rs2_d;
            op_rd_o       <= op_rd_d;
            reg_rd_o      <= reg_rd_d;
            rd_rs1_data_o <= rd_rs1_data_d;
            rd_rs2_data_o <= rd_rs2_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_client.sv
// Scoreboard bench for regfile_client: a behavioural regfile answers strobes, a monitor records outputs,
// and per-scenario tasks compare them against expectations queued when the stimulus is issued.
module tb_regfile_client;

    localparam int unsigned TO_CYC = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        rd_req_i = 1'b0;
    logic [4:0]  rd_rs1_i = '0;
    logic [4:0]  rd_rs2_i = '0;
    logic        rd_ready_o, rd_valid_o;
    logic [31:0] rd_rs1_data_o, rd_rs2_data_o;
    logic        wr_req_i = 1'b0;
    logic [4:0]  wr_rd_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        wr_ready_o, wr_done_o;
    logic        stb_read_o;
    logic [4:0]  op_rs1_o, op_rs2_o;
    logic        ack_read_i = 1'b0;
    logic [31:0] reg_rs1_i = '0;
    logic [31:0] reg_rs2_i = '0;
    logic        stb_write_o;
    logic [4:0]  op_rd_o;
    logic [31:0] reg_rd_o;
    logic        ack_write_i = 1'b0;
    logic        timeout_o;

    regfile_client #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .rd_req_i(rd_req_i), .rd_rs1_i(rd_rs1_i), .rd_rs2_i(rd_rs2_i),
        .rd_ready_o(rd_ready_o), .rd_valid_o(rd_valid_o),
        .rd_rs1_data_o(rd_rs1_data_o), .rd_rs2_data_o(rd_rs2_data_o),
        .wr_req_i(wr_req_i), .wr_rd_i(wr_rd_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o), .wr_done_o(wr_done_o),
        .stb_read_o(stb_read_o), .op_rs1_o(op_rs1_o), .op_rs2_o(op_rs2_o),
        .ack_read_i(ack_read_i), .reg_rs1_i(reg_rs1_i), .reg_rs2_i(reg_rs2_i),
        .stb_write_o(stb_write_o), .op_rd_o(op_rd_o), .reg_rd_o(reg_rd_o),
        .ack_write_i(ack_write_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [4:0] idx; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] d1; logic [31:0] d2; } rd_t;

    wr_t exp_wr_q[$], obs_wr_q[$];
    rd_t exp_rd_q[$], obs_rd_q[$];
    int  done_cyc_q[$], rdv_cyc_q[$], to_cyc_q[$];
    int  n_stb_rd = 0, n_stb_wr = 0, stb_hold = 0;
    rd_t cur_rd = '{32'h0, 32'h0};

    logic [31:0] shadow[32];
    logic [31:0] mem[32];

    bit          resp_en = 1'b1;
    int          ack_dly = 1;
    int          rd_pend = 0, wr_pend = 0;
    logic [4:0]  pend_rs1, pend_rs2;
    bit          stray_rd = 1'b0, stray_wr = 1'b0;
    logic [31:0] stray_d1 = '0, stray_d2 = '0;

    // Behavioural register file: acknowledges ack_dly cycles after seeing a strobe.
    initial begin
        forever begin
            @(negedge clk_i);
            ack_read_i  = 1'b0;
            ack_write_i = 1'b0;
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    ack_read_i = 1'b1;
                    reg_rs1_i  = mem[pend_rs1];
                    reg_rs2_i  = mem[pend_rs2];
                end
            end
            if (wr_pend > 0) begin
                wr_pend--;
                if (wr_pend == 0) ack_write_i = 1'b1;
            end
            if (stray_rd) begin
                ack_read_i = 1'b1;
                reg_rs1_i  = stray_d1;
                reg_rs2_i  = stray_d2;
                stray_rd   = 1'b0;
            end
            if (stray_wr) begin
                ack_write_i = 1'b1;
                stray_wr    = 1'b0;
            end
            if (resp_en && stb_read_o) begin
                rd_pend  = ack_dly;
                pend_rs1 = op_rs1_o;
                pend_rs2 = op_rs2_o;
            end
            if (resp_en && stb_write_o) begin
                wr_pend = ack_dly;
                if (op_rd_o != 5'd0) mem[op_rd_o] = reg_rd_o;
            end
        end
    end

    bit prev_srd = 1'b0, prev_swr = 1'b0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (stb_read_o) begin
                n_stb_rd++;
                if (prev_srd) stb_hold++;
            end
            if (stb_write_o) begin
                n_stb_wr++;
                if (prev_swr) stb_hold++;
                obs_wr_q.push_back('{idx: op_rd_o, data: reg_rd_o});
            end
            prev_srd = stb_read_o;
            prev_swr = stb_write_o;
            if (wr_done_o) done_cyc_q.push_back(cyc);
            if (rd_valid_o) begin
                rdv_cyc_q.push_back(cyc);
                obs_rd_q.push_back('{d1: rd_rs1_data_o, d2: rd_rs2_data_o});
            end
            if (timeout_o) to_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        exp_wr_q.delete(); obs_wr_q.delete();
        exp_rd_q.delete(); obs_rd_q.delete();
        done_cyc_q.delete(); rdv_cyc_q.delete(); to_cyc_q.delete();
    endtask

    // acc is the cycle stamp of the accepting edge (E0), or -1 if never accepted.
    task automatic issue_write(input logic [4:0] rd, input logic [31:0] d, output int acc);
        int n = 0;
        acc = -1;
        @(negedge clk_i);
        #1;
        wr_req_i = 1'b1; wr_rd_i = rd; wr_data_i = d;
        #1;
        while (!wr_ready_o && n < 40) begin
            @(negedge clk_i); #2; n++;
        end
        if (wr_ready_o) begin
            @(posedge clk_i); #1;
            acc = cyc;
            if (rd != 5'd0) begin
                exp_wr_q.push_back('{idx: rd, data: d});
                shadow[rd] = d;
            end
        end
        wr_req_i = 1'b0;
    endtask

    task automatic issue_read(input logic [4:0] rs1, input logic [4:0] rs2, output int acc);
        int n = 0;
        acc = -1;
        @(negedge clk_i);
        #1;
        rd_req_i = 1'b1; rd_rs1_i = rs1; rd_rs2_i = rs2;
        #1;
        while (!rd_ready_o && n < 40) begin
            @(negedge clk_i); #2; n++;
        end
        if (rd_ready_o) begin
            @(posedge clk_i); #1;
            acc = cyc;
            exp_rd_q.push_back('{d1: shadow[rs1], d2: shadow[rs2]});
        end
        rd_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        total++;
        if ({stb_read_o, stb_write_o, rd_valid_o, wr_done_o, timeout_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_pulses: got %b expected 00000",
                     {stb_read_o, stb_write_o, rd_valid_o, wr_done_o, timeout_o});
        end
        total++;
        if ({rd_rs1_data_o, rd_rs2_data_o, reg_rd_o, op_rs1_o, op_rs2_o, op_rd_o} !== '0) begin
            bad++;
            $display("FAIL reset_regs: got %h %h %h %h %h %h expected all zero",
                     rd_rs1_data_o, rd_rs2_data_o, reg_rd_o, op_rs1_o, op_rs2_o, op_rd_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        total++;
        if ({wr_ready_o, rd_ready_o} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready: got %b expected 11", {wr_ready_o, rd_ready_o});
        end
    endtask

    task automatic test_write();
        int acc, sw0, lat;
        wr_t e, o;
        clear_obs();
        resp_en = 1'b1; ack_dly = 1;
        sw0 = n_stb_wr;
        issue_write(5'd5, 32'hDEADBEEF, acc);
        for (int i = 0; i < 20 && done_cyc_q.size() == 0; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        // Done pulse is raised by the second edge after the accepting edge.
        lat = (done_cyc_q.size() > 0 && acc >= 0) ? done_cyc_q[0] - acc : -1;
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL write_latency: got %0d expected 2", lat);
        end
        total++;
        if (done_cyc_q.size() !== 1) begin
            bad++; $display("FAIL write_done_count: got %0d expected 1", done_cyc_q.size());
        end
        total++;
        if (n_stb_wr - sw0 !== 1) begin
            bad++; $display("FAIL write_strobe_count: got %0d expected 1", n_stb_wr - sw0);
        end
        e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '{idx: 5'd0, data: 32'h0};
        o = (obs_wr_q.size() > 0) ? obs_wr_q.pop_front() : '{idx: 5'h1f, data: 32'hFFFF_FFFF};
        total++;
        if (o.idx !== 5'd5 || o.data !== 32'hDEADBEEF || o !== e) begin
            bad++; $display("FAIL write_strobe_fields: got rd=%0d data=%h expected rd=5 data=deadbeef", o.idx, o.data);
        end
    endtask

    task automatic test_read();
        int acc, sr0, lat;
        rd_t e, o;
        clear_obs();
        resp_en = 1'b1; ack_dly = 1;
        sr0 = n_stb_rd;
        issue_read(5'd5, 5'd0, acc);
        for (int i = 0; i < 20 && rdv_cyc_q.size() == 0; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        lat = (rdv_cyc_q.size() > 0 && acc >= 0) ? rdv_cyc_q[0] - acc : -1;
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL read_latency: got %0d expected 2", lat);
        end
        total++;
        if (n_stb_rd - sr0 !== 1 || rdv_cyc_q.size() !== 1) begin
            bad++; $display("FAIL read_pulse_counts: got strobes=%0d valids=%0d expected 1 1",
                            n_stb_rd - sr0, rdv_cyc_q.size());
        end
        e = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : '{d1: 32'h0, d2: 32'h0};
        o = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : '{d1: 32'hX, d2: 32'hX};
        total++;
        if (o.d1 !== 32'hDEADBEEF || o.d2 !== 32'h0 || o !== e) begin
            bad++; $display("FAIL read_data: got %h %h expected deadbeef 00000000", o.d1, o.d2);
        end
        cur_rd = e;
        total++;
        if (rd_rs1_data_o !== e.d1 || rd_rs2_data_o !== e.d2) begin
            bad++; $display("FAIL read_data_held: got %h %h expected %h %h",
                            rd_rs1_data_o, rd_rs2_data_o, e.d1, e.d2);
        end
    endtask

    task automatic test_write_x0();
        int acc, sw0, lat;
        clear_obs();
        sw0 = n_stb_wr;
        issue_write(5'd0, 32'h0000_1234, acc);
        repeat (5) @(negedge clk_i);
        total++;
        if (n_stb_wr - sw0 !== 0) begin
            bad++; $display("FAIL x0_no_strobe: got %0d strobes expected 0", n_stb_wr - sw0);
        end
        lat = (done_cyc_q.size() == 1 && acc >= 0) ? done_cyc_q[0] - acc : -1;
        total++;
        if (lat !== 0) begin
            bad++; $display("FAIL x0_done_timing: got offset %0d (count %0d) expected 0 (count 1)",
                            lat, done_cyc_q.size());
        end
        total++;
        if (op_rd_o !== 5'd0 || reg_rd_o !== 32'h0000_1234) begin
            bad++; $display("FAIL x0_latch: got rd=%0d data=%h expected rd=0 data=00001234", op_rd_o, reg_rd_o);
        end
    endtask

    task automatic test_back_to_back();
        int wacc = -1, racc = -1, s0, lat;
        logic [31:0] x;
        wr_t ew, ow;
        rd_t er, orr;
        clear_obs();
        resp_en = 1'b1; ack_dly = 1;
        s0 = n_stb_rd + n_stb_wr;
        x = 32'hC0FFEE01;
        @(negedge clk_i); #1;
        wr_req_i = 1'b1; wr_rd_i = 5'd7; wr_data_i = x;
        rd_req_i = 1'b1; rd_rs1_i = 5'd7; rd_rs2_i = 5'd5;
        #1;
        total++;
        if ({wr_ready_o, rd_ready_o} !== 2'b10) begin
            bad++; $display("FAIL collide_ready: got %b expected 10", {wr_ready_o, rd_ready_o});
        end
        if (wr_ready_o) begin
            @(posedge clk_i); #1;
            wacc = cyc;
            exp_wr_q.push_back('{idx: 5'd7, data: x});
            shadow[7] = x;
        end
        wr_req_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i); #2;
            if (rd_ready_o) begin
                @(posedge clk_i); #1;
                racc = cyc;
                exp_rd_q.push_back('{d1: shadow[7], d2: shadow[5]});
                break;
            end
        end
        rd_req_i = 1'b0;
        for (int i = 0; i < 20 && rdv_cyc_q.size() == 0; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        lat = (wacc >= 0 && racc >= 0) ? racc - wacc : -1;
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL b2b_accept_spacing: got %0d expected 3", lat);
        end
        total++;
        if (n_stb_rd + n_stb_wr - s0 !== 2) begin
            bad++; $display("FAIL b2b_strobe_total: got %0d expected 2", n_stb_rd + n_stb_wr - s0);
        end
        ew = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '{idx: 5'd0, data: 32'h0};
        ow = (obs_wr_q.size() > 0) ? obs_wr_q.pop_front() : '{idx: 5'h1f, data: 32'hX};
        total++;
        if (ow !== ew) begin
            bad++; $display("FAIL b2b_write: got rd=%0d data=%h expected rd=%0d data=%h", ow.idx, ow.data, ew.idx, ew.data);
        end
        er  = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : '{d1: 32'h0, d2: 32'h0};
        orr = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : '{d1: 32'hX, d2: 32'hX};
        total++;
        if (orr !== er) begin
            bad++; $display("FAIL b2b_read: got %h %h expected %h %h", orr.d1, orr.d2, er.d1, er.d2);
        end
        cur_rd = er;
    endtask

    task automatic test_random_stream();
        int acc, nw = 0, nr = 0;
        wr_t ew, ow;
        rd_t er, orr;
        clear_obs();
        resp_en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            ack_dly = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                issue_write(5'($urandom_range(0, 31)), $urandom, acc);
                nw++;
            end else begin
                issue_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), acc);
                nr++;
            end
        end
        for (int i = 0; i < 20; i++) @(negedge clk_i);
        total++;
        if (done_cyc_q.size() !== nw || rdv_cyc_q.size() !== nr || stb_hold !== 0) begin
            bad++; $display("FAIL stream_counts: got done=%0d valid=%0d held=%0d expected %0d %0d 0",
                            done_cyc_q.size(), rdv_cyc_q.size(), stb_hold, nw, nr);
        end
        total++;
        if (obs_wr_q.size() !== exp_wr_q.size() || obs_rd_q.size() !== exp_rd_q.size()) begin
            bad++; $display("FAIL stream_queue_sizes: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                            obs_wr_q.size(), obs_rd_q.size(), exp_wr_q.size(), exp_rd_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front(); ow = obs_wr_q.pop_front();
            total++;
            if (ow !== ew) begin
                bad++; $display("FAIL stream_write: got rd=%0d data=%h expected rd=%0d data=%h", ow.idx, ow.data, ew.idx, ew.data);
            end
        end
        while (exp_rd_q.size() > 0 && obs_rd_q.size() > 0) begin
            er = exp_rd_q.pop_front(); orr = obs_rd_q.pop_front();
            total++;
            if (orr !== er) begin
                bad++; $display("FAIL stream_read: got %h %h expected %h %h", orr.d1, orr.d2, er.d1, er.d2);
            end
            cur_rd = er;
        end
    endtask

    task automatic test_stray_ack();
        int acc, lat;
        rd_t er, orr;
        clear_obs();
        resp_en = 1'b1;
        @(negedge clk_i); #1;
        stray_d1 = 32'hA5A5_A5A5; stray_d2 = 32'h5A5A_5A5A;
        stray_rd = 1'b1;
        @(negedge clk_i); #1;
        stray_wr = 1'b1;
        repeat (4) @(negedge clk_i);
        #1;
        total++;
        if (rdv_cyc_q.size() !== 0 || done_cyc_q.size() !== 0 || rd_rs1_data_o !== cur_rd.d1 || rd_rs2_data_o !== cur_rd.d2) begin
            bad++; $display("FAIL stray_idle: got valid=%0d done=%0d data=%h %h expected 0 0 %h %h",
                            rdv_cyc_q.size(), done_cyc_q.size(), rd_rs1_data_o, rd_rs2_data_o, cur_rd.d1, cur_rd.d2);
        end
        // Wrong-type acknowledge during a read, then the real one a cycle later.
        resp_en = 1'b0;
        issue_read(5'd3, 5'd4, acc);
        @(negedge clk_i); #1;
        stray_wr = 1'b1;
        @(negedge clk_i); #1;
        stray_d1 = mem[3]; stray_d2 = mem[4];
        stray_rd = 1'b1;
        repeat (4) @(negedge clk_i);
        lat = (rdv_cyc_q.size() == 1 && acc >= 0) ? rdv_cyc_q[0] - acc : -1;
        total++;
        if (lat !== 3 || done_cyc_q.size() !== 0) begin
            bad++; $display("FAIL cross_ack: got valid offset=%0d done=%0d expected 3 0", lat, done_cyc_q.size());
        end
        er  = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : '{d1: 32'h0, d2: 32'h0};
        orr = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : '{d1: 32'hX, d2: 32'hX};
        total++;
        if (orr !== er) begin
            bad++; $display("FAIL cross_ack_data: got %h %h expected %h %h", orr.d1, orr.d2, er.d1, er.d2);
        end
        cur_rd = er;
        resp_en = 1'b1;
    endtask

    task automatic test_timeout();
        int acc, lat;
        clear_obs();
        resp_en = 1'b0;
        issue_read(5'd9, 5'd10, acc);
        exp_rd_q.delete();
`ifdef REGFILE_TIMEOUT_EN
        for (int i = 0; i < 12 && to_cyc_q.size() == 0; i++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        lat = (to_cyc_q.size() == 1 && acc >= 0) ? to_cyc_q[0] - acc : -1;
        total++;
        if (lat !== TO_CYC) begin
            bad++; $display("FAIL timeout_pulse: got offset %0d (count %0d) expected %0d (count 1)", lat, to_cyc_q.size(), TO_CYC);
        end
        #1;
        stray_d1 = 32'h1357_9BDF; stray_d2 = 32'h2468_ACE0;
        stray_rd = 1'b1;
        repeat (4) @(negedge clk_i);
        #1;
        total++;
        if (rdv_cyc_q.size() !== 0 || rd_rs1_data_o !== cur_rd.d1 || rd_rs2_data_o !== cur_rd.d2 || wr_ready_o !== 1'b1) begin
            bad++; $display("FAIL timeout_late_ack: got valid=%0d data=%h %h ready=%b expected 0 %h %h 1",
                            rdv_cyc_q.size(), rd_rs1_data_o, rd_rs2_data_o, wr_ready_o, cur_rd.d1, cur_rd.d2);
        end
`else
        repeat (20) @(negedge clk_i);
        #1;
        total++;
        if (to_cyc_q.size() !== 0 || rdv_cyc_q.size() !== 0 || rd_ready_o !== 1'b0) begin
            bad++; $display("FAIL no_timeout_wait: got timeouts=%0d valid=%0d ready=%b expected 0 0 0",
                            to_cyc_q.size(), rdv_cyc_q.size(), rd_ready_o);
        end
        stray_d1 = mem[9]; stray_d2 = mem[10];
        stray_rd = 1'b1;
        repeat (4) @(negedge clk_i);
        #1;
        total++;
        if (rdv_cyc_q.size() !== 1 || rd_rs1_data_o !== shadow[9] || rd_rs2_data_o !== shadow[10]) begin
            bad++; $display("FAIL no_timeout_late_complete: got valid=%0d data=%h %h expected 1 %h %h",
                            rdv_cyc_q.size(), rd_rs1_data_o, rd_rs2_data_o, shadow[9], shadow[10]);
        end
        cur_rd = '{d1: shadow[9], d2: shadow[10]};
`endif
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        rd_t er, orr;
        clear_obs();
        resp_en = 1'b0;
        issue_read(5'd5, 5'd7, acc);
        @(negedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({stb_read_o, stb_write_o, rd_valid_o, wr_done_o, timeout_o} !== 5'b0 ||
            {rd_rs1_data_o, rd_rs2_data_o, reg_rd_o, op_rs1_o, op_rs2_o, op_rd_o} !== '0) begin
            bad++; $display("FAIL mid_reset_async: got pulses=%b data=%h %h op=%0d %0d expected all zero",
                            {stb_read_o, stb_write_o, rd_valid_o, wr_done_o, timeout_o},
                            rd_rs1_data_o, rd_rs2_data_o, op_rs1_o, op_rs2_o);
        end
        exp_rd_q.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        total++;
        if (rdv_cyc_q.size() !== 0 || done_cyc_q.size() !== 0) begin
            bad++; $display("FAIL mid_reset_dropped: got valid=%0d done=%0d expected 0 0", rdv_cyc_q.size(), done_cyc_q.size());
        end
        resp_en = 1'b1; ack_dly = 1;
        issue_read(5'd5, 5'd7, acc);
        for (int i = 0; i < 20 && rdv_cyc_q.size() == 0; i++) @(negedge clk_i);
        lat = (rdv_cyc_q.size() > 0 && acc >= 0) ? rdv_cyc_q[0] - acc : -1;
        er  = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : '{d1: 32'h0, d2: 32'h0};
        orr = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : '{d1: 32'hX, d2: 32'hX};
        total++;
        if (lat !== 2 || orr !== er) begin
            bad++; $display("FAIL mid_reset_recover: got latency=%0d data=%h %h expected 2 %h %h", lat, orr.d1, orr.d2, er.d1, er.d2);
        end
    endtask

    initial begin
        shadow[0] = 32'h0;
        mem[0]    = 32'h0;
        for (int i = 1; i < 32; i++) begin
            shadow[i] = $urandom;
            mem[i]    = shadow[i];
        end
        test_reset();
        test_write();
        test_read();
        test_write_x0();
        test_back_to_back();
        test_random_stream();
        test_stray_ack();
        test_timeout();
        test_reset_mid();
        total++;
        if (stb_hold !== 0) begin
            bad++; $display("FAIL strobe_single_cycle: got %0d held strobes expected 0", stb_hold);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
